// File: rtl/pdm_mic_frontend.sv
// rtl/pdm_mic_frontend.sv - PDM microphone clock generator, bit capture and optional tally (PDM_TALLY_EN)
module pdm_mic_frontend #(
  parameter int PDM_COUNT_PERIOD = 32,
  parameter int NUM_PDM_SAMPLES  = 256
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               en_in,
  input  logic               mic_data_in,
  output logic               mic_clk_out,
  output logic               pdm_valid_out,
  output logic               pdm_bit_out,
  output logic signed [15:0] pdm_sample_out,
  output logic               tally_valid_out,
  output logic signed [15:0] tally_out
);

  localparam int CW = $clog2(PDM_COUNT_PERIOD);
  localparam logic [CW-1:0] LAST = CW'(PDM_COUNT_PERIOD - 1);
  localparam logic [CW-1:0] HALF = CW'(PDM_COUNT_PERIOD / 2);

  logic [CW-1:0] cnt;
  logic          mic_clk_d;
  logic          sync1, sync2;
  logic          rise;

  assign rise = mic_clk_out & ~mic_clk_d;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      cnt            <= '0;
      mic_clk_out    <= 1'b0;
      mic_clk_d      <= 1'b0;
      sync1          <= 1'b0;
      sync2          <= 1'b0;
      pdm_valid_out  <= 1'b0;
      pdm_bit_out    <= 1'b0;
      pdm_sample_out <= '0;
    end else begin
      sync1         <= mic_data_in;
      sync2         <= sync1;
      mic_clk_d     <= mic_clk_out;
      // Capture is driven by the clock edge alone, so a rise that meets en_in falling still strobes
      pdm_valid_out <= rise;
      if (rise) begin
        pdm_bit_out    <= sync2;
        pdm_sample_out <= sync2 ? 16'sh7FFF : 16'sh8001;
      end
      if (en_in) begin
        cnt         <= (cnt == LAST) ? '0 : cnt + 1'b1;
        mic_clk_out <= (cnt < HALF);
      end else begin
        cnt         <= '0;
        mic_clk_out <= 1'b0;
      end
    end
  end

`ifdef PDM_TALLY_EN
  logic [15:0] win;
  logic [15:0] ones;
  logic [15:0] ones_next;
  logic [16:0] tally_diff;
  logic        tally_ok;

  assign ones_next  = ones + {15'd0, pdm_bit_out};
  assign tally_diff = {ones_next, 1'b0} - 17'(NUM_PDM_SAMPLES);

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      win             <= '0;
      ones            <= '0;
      tally_ok        <= 1'b0;
      tally_valid_out <= 1'b0;
      tally_out       <= '0;
    end else begin
      // Strobes whose rise happened with en_in low are emitted but never counted
      tally_ok        <= rise & en_in;
      tally_valid_out <= 1'b0;
      if (!en_in) begin
        win  <= '0;
        ones <= '0;
      end else if (pdm_valid_out && tally_ok) begin
        if (win == 16'(NUM_PDM_SAMPLES - 1)) begin
          win             <= '0;
          ones            <= '0;
          tally_out       <= $signed(tally_diff[15:0]);
          tally_valid_out <= 1'b1;
        end else begin
          win  <= win + 16'd1;
          ones <= ones_next;
        end
      end
    end
  end
`else
  assign tally_out       = '0;
  assign tally_valid_out = 1'b0;
`endif

endmodule

// File: doc/pdm_mic_frontend.md
PDM_MIC_FRONTEND -- requirements
Module: pdm_mic_frontend

Interface
REQ-001 Parameter PDM_COUNT_PERIOD, default 32: system clocks per mic clock period; even, >= 4.
REQ-002 Parameter NUM_PDM_SAMPLES, default 256: PDM samples per tally window; 2..32767.
REQ-003 clk_in  input  1: sole clock, 100 MHz system clock.
REQ-004 rst_in  input  1: asynchronous active-high reset.
REQ-005 en_in  input  1: run enable; low halts mic clock and sampling.
REQ-006 mic_data_in  input  1: raw PDM bit from microphone, asynchronous to clk_in.
REQ-007 mic_clk_out  output  1: clock driven to microphone.
REQ-008 pdm_valid_out  output  1: one-cycle strobe per captured PDM bit.
REQ-009 pdm_bit_out  output  1: last captured PDM bit.
REQ-010 pdm_sample_out  output  16 signed: bipolar sample for the first fir_decimator stage.
REQ-011 tally_valid_out  output  1: one-cycle strobe per completed tally window.
REQ-012 tally_out  output  16 signed: window average, 2*ones - NUM_PDM_SAMPLES.

Function
REQ-013 Period counter SHALL count 0..PDM_COUNT_PERIOD-1 and wrap to 0 while en_in high.
REQ-014 mic_clk_out SHALL be registered: high when counter < PDM_COUNT_PERIOD/2, else low (50% duty).
REQ-015 mic_data_in SHALL pass through a 2-flop synchronizer before any use.
REQ-016 Rise event: cycle in which mic_clk_out is high and was low the previous cycle.
REQ-017 Cycle after a rise event: pdm_valid_out high for exactly one cycle; pdm_bit_out = synchronizer output captured in the rise cycle.
REQ-018 pdm_sample_out SHALL update with pdm_valid_out: bit 1 -> 16'sh7FFF, bit 0 -> 16'sh8001; held otherwise.
REQ-019 pdm_valid_out SHALL occur exactly once per PDM_COUNT_PERIOD cycles in steady state.
REQ-020 Window counter SHALL count pdm_valid_out strobes 0..NUM_PDM_SAMPLES-1; ones counter adds pdm_bit_out each strobe.
REQ-021 On the strobe completing the window (count = NUM_PDM_SAMPLES-1): next cycle tally_out = 2*ones - NUM_PDM_SAMPLES including that strobe's bit, tally_valid_out high one cycle; both counters restart at 0 with no sample lost or double-counted.
REQ-022 tally_out SHALL hold between windows.
REQ-023 en_in falling: next cycle mic_clk_out low, period counter 0, window and ones counters 0; no strobes while low; pdm_bit_out, pdm_sample_out, tally_out hold.
REQ-024 en_in rising: sequence resumes exactly as after reset release (first rise event one cycle later).
REQ-025 A rise event coinciding with en_in falling SHALL still emit its pdm_valid_out; its bit is not tallied.

Reset
REQ-026 rst_in high SHALL asynchronously clear: mic_clk_out 0, pdm_valid_out 0, pdm_bit_out 0, pdm_sample_out 0, tally_valid_out 0, tally_out 0, all counters and synchronizer flops 0.
REQ-027 Reset mid-window SHALL discard the partial tally; first window after release is a full NUM_PDM_SAMPLES.

Configuration
REQ-028 Macro PDM_TALLY_EN defined: window/ones counters and tally outputs per REQ-020..022.
REQ-029 PDM_TALLY_EN undefined: tally logic absent; tally_out constant 0, tally_valid_out constant 0; all other behaviour unchanged.

Verification
REQ-030 Reset, en_in=1, defaults -> mic_clk_out 16 high/16 low cycles; pdm_valid_out every 32 cycles, one cycle wide.
REQ-031 mic_data_in=1 constant, PDM_TALLY_EN -> pdm_sample_out 16'sh7FFF; tally_out 256 every 256 strobes (8192 cycles).
REQ-032 mic_data_in=0 constant -> pdm_sample_out 16'sh8001, tally_out -256; alternating bit per strobe -> tally_out 0.
REQ-033 en_in dropped 100 cycles then raised mid-window -> no strobes while low; next tally_valid_out exactly 256 strobes after resume.
REQ-034 rst_in pulsed asynchronously mid-window -> all outputs 0 immediately; first tally 256 strobes after release.
REQ-035 PDM_TALLY_EN undefined, constant 1 input -> tally_valid_out never asserts, tally_out 0; pdm outputs as REQ-031.
